// File: rtl/draw_arbiter_pkg.sv
// Shared graphics definitions: arbiter state encoding, engine opcodes and
// vertex coordinate indices used by the draw arbiter and its helpers.
package draw_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_ACK   = 2'd3
   } arb_state_e;

   localparam logic [2:0] OP_NOP      = 3'd0;
   localparam logic [2:0] OP_TRIANGLE = 3'd1;

   localparam int IDX_AX  = 0;
   localparam int IDX_AY  = 1;
   localparam int IDX_AZ  = 2;
   localparam int IDX_BX  = 3;
   localparam int IDX_BY  = 4;
   localparam int IDX_BZ  = 5;
   localparam int IDX_CX  = 6;
   localparam int IDX_CY  = 7;
   localparam int IDX_CZ  = 8;
   localparam int N_COORD = 9;

   // Index width for a requester count, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/draw_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward
// from last+1, wrapping modulo N_REQ.
module rr_pick
   import draw_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_last,
   output logic             o_valid,
   output logic [IDX_W-1:0] o_idx
);

   int w_pos;

   // Scan from the farthest offset down so the nearest hit is written last.
   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      w_pos   = 0;
      for (int k = N_REQ; k >= 1; k--) begin
         w_pos = (int'(i_last) + k) % N_REQ;
         if (i_req[w_pos]) begin
            o_valid = 1'b1;
            o_idx   = IDX_W'(w_pos);
         end
      end
   end

endmodule

// File: rtl/draw_arbiter.sv
// Round-robin arbiter sharing one triangle drawing engine among N_REQ units.
// Optional watchdog on the engine handshake enabled by DRAW_ARB_TIMEOUT_EN.
//
// state   | meaning
// S_IDLE  | no owner; pick a winner and latch its operands
// S_START | draw_en pulse to the engine
// S_WAIT  | engine running, waiting for draw_done
// S_ACK   | one-cycle ack to the owner, grant released
module draw_arbiter
   import draw_arbiter_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int COLOUR_WIDTH   = 3,
   parameter int N_REQ          = 4,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic                              i_clock,
   input  logic                              i_reset,
   input  logic [N_REQ-1:0]                  i_req,
   input  logic [3*N_REQ-1:0]                i_req_opcode,
   input  logic [N_COORD*WIDTH*N_REQ-1:0]    i_req_coords,
   input  logic [COLOUR_WIDTH*N_REQ-1:0]     i_req_colour,
   output logic [N_REQ-1:0]                  o_ack,
   output logic [N_REQ-1:0]                  o_grant,
   output logic                              o_busy,
   output logic [2:0]                        o_opcode,
   output logic [WIDTH-1:0]                  o_ax,
   output logic [WIDTH-1:0]                  o_ay,
   output logic [WIDTH-1:0]                  o_az,
   output logic [WIDTH-1:0]                  o_bx,
   output logic [WIDTH-1:0]                  o_by,
   output logic [WIDTH-1:0]                  o_bz,
   output logic [WIDTH-1:0]                  o_cx,
   output logic [WIDTH-1:0]                  o_cy,
   output logic [WIDTH-1:0]                  o_cz,
   output logic [COLOUR_WIDTH-1:0]           o_colour,
   output logic                              o_draw_en,
   input  logic                              i_draw_done
`ifdef DRAW_ARB_TIMEOUT_EN
   ,
   output logic                              o_timeout_err
`endif
);

   localparam int IDX_W = idx_w(N_REQ);

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("draw_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES positive");
   end

   arb_state_e                      r_state;
   logic [IDX_W-1:0]                r_last;
   logic [N_REQ-1:0]                r_grant;
   logic [N_REQ-1:0]                r_ack;
   logic                            r_busy;
   logic                            r_draw_en;
   logic [2:0]                      r_opcode;
   logic [N_COORD-1:0][WIDTH-1:0]   r_coord;
   logic [COLOUR_WIDTH-1:0]         r_colour;
   logic                            w_valid;
   logic [IDX_W-1:0]                w_idx;

`ifdef DRAW_ARB_TIMEOUT_EN
   localparam logic [31:0] L_WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);
   logic [31:0] r_wdog;
   logic        r_timeout_err;
   assign o_timeout_err = r_timeout_err;
`endif

   rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
      .i_req   (i_req),
      .i_last  (r_last),
      .o_valid (w_valid),
      .o_idx   (w_idx)
   );

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_state   <= S_IDLE;
         r_last    <= IDX_W'(N_REQ - 1);
         r_grant   <= '0;
         r_ack     <= '0;
         r_busy    <= 1'b0;
         r_draw_en <= 1'b0;
         r_opcode  <= '0;
         r_coord   <= '0;
         r_colour  <= '0;
`ifdef DRAW_ARB_TIMEOUT_EN
         r_wdog        <= '0;
         r_timeout_err <= 1'b0;
`endif
      end else begin
         r_draw_en <= 1'b0;
         r_ack     <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_valid) begin
                  r_opcode  <= i_req_opcode[int'(w_idx)*3 +: 3];
                  r_coord   <= i_req_coords[int'(w_idx)*N_COORD*WIDTH +: N_COORD*WIDTH];
                  r_colour  <= i_req_colour[int'(w_idx)*COLOUR_WIDTH +: COLOUR_WIDTH];
                  r_grant   <= N_REQ'(1) << w_idx;
                  r_last    <= w_idx;
                  r_busy    <= 1'b1;
                  r_draw_en <= 1'b1;
                  r_state   <= S_START;
               end
            end
            S_START: begin
               // draw_done here is ignored; the engine cannot finish this early.
`ifdef DRAW_ARB_TIMEOUT_EN
               r_wdog  <= '0;
`endif
               r_state <= S_WAIT;
            end
            S_WAIT: begin
`ifdef DRAW_ARB_TIMEOUT_EN
               r_wdog <= r_wdog + 32'd1;
               if (i_draw_done || r_wdog == L_WDOG_LAST) begin
                  r_ack   <= r_grant;
                  r_state <= S_ACK;
                  if (!i_draw_done) begin
                     r_timeout_err <= 1'b1;
                  end
               end
`else
               if (i_draw_done) begin
                  r_ack   <= r_grant;
                  r_state <= S_ACK;
               end
`endif
            end
            S_ACK: begin
               r_grant <= '0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_ack     = r_ack;
   assign o_grant   = r_grant;
   assign o_busy    = r_busy;
   assign o_draw_en = r_draw_en;
   assign o_opcode  = r_opcode;
   assign o_colour  = r_colour;
   assign o_ax      = r_coord[IDX_AX];
   assign o_ay      = r_coord[IDX_AY];
   assign o_az      = r_coord[IDX_AZ];
   assign o_bx      = r_coord[IDX_BX];
   assign o_by      = r_coord[IDX_BY];
   assign o_bz      = r_coord[IDX_BZ];
   assign o_cx      = r_coord[IDX_CX];
   assign o_cy      = r_coord[IDX_CY];
   assign o_cz      = r_coord[IDX_CZ];

endmodule

// File: tb/tb_draw_arbiter.sv
// Scoreboard bench for draw_arbiter: expected winners and operands are queued
// as requests are raised and compared when the arbiter starts each draw.
module tb_draw_arbiter;
   import draw_arbiter_pkg::*;

   localparam int W  = 32;
   localparam int CW = 3;
   localparam int N  = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [N-1:0]      req;
   logic [3*N-1:0]    req_op;
   logic [9*W*N-1:0]  req_co;
   logic [CW*N-1:0]   req_col;
   logic              done;
   logic [N-1:0]      ack, grant;
   logic              busy, draw_en;
   logic [2:0]        opcode;
   logic [W-1:0]      ax, ay, az, bx, by, bz, cx, cy, cz;
   logic [CW-1:0]     colour;
`ifdef DRAW_ARB_TIMEOUT_EN
   logic              timeout_err;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int gen     = 0;

   typedef struct {
      int                  idx;
      logic [2:0]          op;
      logic [8:0][W-1:0]   co;
      logic [CW-1:0]       col;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   draw_arbiter #(
      .WIDTH(W), .COLOUR_WIDTH(CW), .N_REQ(N)
`ifdef DRAW_ARB_TIMEOUT_EN
      , .TIMEOUT_CYCLES(16)
`endif
   ) dut (
      .i_clock(clk), .i_reset(rst_n), .i_req(req), .i_req_opcode(req_op),
      .i_req_coords(req_co), .i_req_colour(req_col),
      .o_ack(ack), .o_grant(grant), .o_busy(busy), .o_opcode(opcode),
      .o_ax(ax), .o_ay(ay), .o_az(az), .o_bx(bx), .o_by(by), .o_bz(bz),
      .o_cx(cx), .o_cy(cy), .o_cz(cz), .o_colour(colour),
      .o_draw_en(draw_en), .i_draw_done(done)
`ifdef DRAW_ARB_TIMEOUT_EN
      , .o_timeout_err(timeout_err)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] f_coord(input int g, input int i, input int k);
      return W'(g*5000 + i*1000 + (k+1)*10);
   endfunction

   function automatic logic [2:0] f_op(input int g, input int i);
      return 3'((i + 1 + g) & 7);
   endfunction

   function automatic logic [CW-1:0] f_col(input int g, input int i);
      return CW'((5 + i + g) & 7);
   endfunction

   task automatic drive_ops();
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < 9; k++) req_co[(9*i+k)*W +: W] = f_coord(gen, i, k);
         req_op[3*i +: 3]    = f_op(gen, i);
         req_col[CW*i +: CW] = f_col(gen, i);
      end
   endtask

   task automatic push_exp(input int i);
      exp_t e;
      e.idx = i;
      e.op  = f_op(gen, i);
      e.col = f_col(gen, i);
      for (int k = 0; k < 9; k++) e.co[k] = f_coord(gen, i, k);
      sb.push_back(e);
   endtask

   task automatic chk_ops(input exp_t e);
      logic [W-1:0] oc [9];
      oc = '{ax, ay, az, bx, by, bz, cx, cy, cz};
      chk("opcode", 64'(opcode), 64'(e.op));
      chk("colour", 64'(colour), 64'(e.col));
      for (int k = 0; k < 9; k++) chk($sformatf("coord%0d", k), 64'(oc[k]), 64'(e.co[k]));
   endtask

   task automatic take_grant(input int exp_lat, output exp_t e);
      int n;
      logic [N-1:0] g;
      n = 0;
      while (!draw_en && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("draw_en_seen", 64'(draw_en), 64'd1);
      if (exp_lat > 0) chk("draw_en_latency", 64'(n), 64'(exp_lat));
      chk("sb_pending", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) e = sb.pop_front();
      g = N'(1) << e.idx;
      chk("grant", 64'(grant), 64'(g));
      chk("busy_start", 64'(busy), 64'd1);
      chk_ops(e);
   endtask

   // One full transaction: draw_en seen, engine runs `delay` cycles, ack checked.
   task automatic serve(input int delay, input bit early, input int exp_lat,
                        input logic [N-1:0] set_mask, input logic [N-1:0] clr_mask);
      exp_t e;
      logic [N-1:0] g;
      take_grant(exp_lat, e);
      g = N'(1) << e.idx;
      if (early) done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      req  = req | set_mask;
      chk("draw_en_one_cycle", 64'(draw_en), 64'd0);
      for (int c = 1; c < delay; c++) begin
         @(negedge clk);
         chk("no_early_ack", 64'(ack), 64'd0);
         chk("grant_hold", 64'(grant), 64'(g));
      end
      chk_ops(e);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      chk("ack", 64'(ack), 64'(g));
      req = req & ~clr_mask;
      @(negedge clk);
      chk("ack_one_cycle", 64'(ack), 64'd0);
      chk("grant_clear", 64'(grant), 64'd0);
      chk("busy_clear", 64'(busy), 64'd0);
   endtask

   initial begin
      exp_t e;
      int   k;
      req  = '0;
      done = 1'b0;
      drive_ops();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_ack", 64'(ack), 64'd0);
      chk("rst_draw_en", 64'(draw_en), 64'd0);
      chk("rst_opcode", 64'(opcode), 64'd0);
      chk("rst_ax", 64'(ax), 64'd0);
`ifdef DRAW_ARB_TIMEOUT_EN
      chk("rst_timeout_err", 64'(timeout_err), 64'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      // Single requester, then back-to-back re-win.
      req = 4'b0001;
      push_exp(0);
      serve(7, 1'b0, 1, '0, '0);
      push_exp(0);
      serve(2, 1'b0, 1, '0, 4'b0001);

      // Fairness from a fresh pointer.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      req = 4'b1011;
      push_exp(0); push_exp(1); push_exp(3);
      push_exp(0); push_exp(1); push_exp(3);
      for (int i = 0; i < 5; i++) serve(3, 1'b0, 1, '0, '0);
      serve(3, 1'b0, 1, '0, 4'b1011);
      @(negedge clk);
      chk("idle_after_fair", 64'(busy), 64'd0);

      // Wrap from last=3; req[2] raised mid-draw waits its turn.
      req = 4'b1001;
      push_exp(0);
      serve(4, 1'b0, 1, 4'b0100, 4'b0001);
      push_exp(2);
      serve(3, 1'b0, 1, '0, 4'b0100);
      push_exp(3);
      serve(2, 1'b0, 1, '0, 4'b1000);

      // Early draw_done in S_START ignored.
      gen = 1;
      drive_ops();
      req = 4'b0010;
      push_exp(1);
      serve(5, 1'b1, 1, '0, 4'b0010);

      // Reset during S_WAIT.
      req = 4'b0010;
      @(negedge clk);
      chk("pre_rst_draw_en", 64'(draw_en), 64'd1);
      chk("pre_rst_grant", 64'(grant), 64'b0010);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_grant", 64'(grant), 64'd0);
      chk("mid_rst_draw_en", 64'(draw_en), 64'd0);
      chk("mid_rst_ack", 64'(ack), 64'd0);
      chk("mid_rst_opcode", 64'(opcode), 64'd0);
      chk("mid_rst_colour", 64'(colour), 64'd0);
      chk("mid_rst_ops", 64'(|{ax, ay, az, bx, by, bz, cx, cy, cz}), 64'd0);
      gen = 2;
      drive_ops();
      rst_n = 1'b1;
      push_exp(1);
      serve(3, 1'b0, 1, '0, 4'b0010);

`ifdef DRAW_ARB_TIMEOUT_EN
      // Engine never answers: watchdog completes the handshake.
      req = 4'b0100;
      push_exp(2);
      take_grant(1, e);
      k = 0;
      while (ack == '0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("wdog_ack_cycles", 64'(k), 64'd17);
      chk("wdog_ack", 64'(ack), 64'b0100);
      chk("wdog_err", 64'(timeout_err), 64'd1);
      req = '0;
      repeat (2) @(negedge clk);
      req = 4'b0001;
      push_exp(0);
      serve(2, 1'b0, 1, '0, 4'b0001);
      chk("wdog_err_sticky", 64'(timeout_err), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("wdog_err_reset", 64'(timeout_err), 64'd0);
`endif

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
